// File: rtl/analyzer_pkg.sv
// Shared definitions for the analyzer command/response path: field widths,
// frame lengths and the response encoder state set.
package analyzer_pkg;

  localparam int OPCODE_W           = 8;
  localparam int PAYLOAD_W          = 32;
  localparam int FRAME_BYTES_NOCSUM = 5;
  localparam int FRAME_BYTES_CSUM   = 6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    OPC   = 3'd1,
    BYTE0 = 3'd2,
    BYTE1 = 3'd3,
    BYTE2 = 3'd4,
    BYTE3 = 3'd5,
    CSUM  = 3'd6,
    DONE  = 3'd7
  } rsp_state_e;

endpackage

// File: rtl/response_encoder_if.sv
// Response request side plus serialized byte side of the response encoder.
// Handshake: a transfer happens on a rising clock edge where valid && ready;
// the source holds valid and its data stable until then, and ready never
// depends combinationally on valid.
interface response_encoder_if;
  import analyzer_pkg::*;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [OPCODE_W-1:0]  opcode;
  logic [PAYLOAD_W-1:0] response;
  logic [7:0]           byte_out;
  logic                 byte_out_valid;
  logic                 byte_out_ready;
  logic                 rsp_sent;

  modport master (
    output rsp_valid, opcode, response, byte_out_ready,
    input  rsp_ready, byte_out, byte_out_valid, rsp_sent
  );

  modport slave (
    input  rsp_valid, opcode, response, byte_out_ready,
    output rsp_ready, byte_out, byte_out_valid, rsp_sent
  );

endinterface

// File: rtl/response_encoder.sv
// Serializes an opcode + 32-bit response into a byte stream (MSB first),
// optionally followed by an XOR checksum byte, then pulses rsp_sent.
module response_encoder
  import analyzer_pkg::*;
#(
  parameter bit CHECKSUM_EN = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  response_encoder_if.slave rsp_if,
  output rsp_state_e        state_dbg
);

  rsp_state_e           state_q;
  rsp_state_e           state_d;
  logic [OPCODE_W-1:0]  opcode_q;
  logic [PAYLOAD_W-1:0] payload_q;
  logic [7:0]           csum_q;

  logic                 rsp_ready;
  logic                 byte_valid;
  logic                 rsp_sent;
  logic [7:0]           byte_out;
  logic                 accept;
  logic                 byte_acc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs decode from state_q and latched data only; ready/valid inputs
  // steer next-state alone, so no input reaches an output combinationally.
  always_comb begin
    state_d    = state_q;
    rsp_ready  = 1'b0;
    byte_valid = 1'b0;
    rsp_sent   = 1'b0;
    byte_out   = 8'h00;
    case (state_q)
      IDLE: begin
        rsp_ready = 1'b1;
        if (rsp_if.rsp_valid) state_d = OPC;
      end
      OPC: begin
        byte_valid = 1'b1;
        byte_out   = opcode_q;
        if (rsp_if.byte_out_ready) state_d = BYTE0;
      end
      BYTE0: begin
        byte_valid = 1'b1;
        byte_out   = payload_q[31:24];
        if (rsp_if.byte_out_ready) state_d = BYTE1;
      end
      BYTE1: begin
        byte_valid = 1'b1;
        byte_out   = payload_q[23:16];
        if (rsp_if.byte_out_ready) state_d = BYTE2;
      end
      BYTE2: begin
        byte_valid = 1'b1;
        byte_out   = payload_q[15:8];
        if (rsp_if.byte_out_ready) state_d = BYTE3;
      end
      BYTE3: begin
        byte_valid = 1'b1;
        byte_out   = payload_q[7:0];
        if (rsp_if.byte_out_ready) state_d = CHECKSUM_EN ? CSUM : DONE;
      end
      CSUM: begin
        byte_valid = 1'b1;
        byte_out   = csum_q;
        if (rsp_if.byte_out_ready) state_d = DONE;
      end
      DONE: begin
        rsp_sent = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept   = rsp_ready && rsp_if.rsp_valid;
  assign byte_acc = byte_valid && rsp_if.byte_out_ready;

  // Checksum folds in each data byte as it is accepted, so it is complete
  // by the time CSUM presents it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      opcode_q  <= '0;
      payload_q <= '0;
      csum_q    <= 8'h00;
    end else if (accept) begin
      opcode_q  <= rsp_if.opcode;
      payload_q <= rsp_if.response;
      csum_q    <= 8'h00;
    end else if (byte_acc && (state_q != CSUM)) begin
      csum_q <= csum_q ^ byte_out;
    end
  end

  assign rsp_if.rsp_ready      = rsp_ready;
  assign rsp_if.byte_out       = byte_out;
  assign rsp_if.byte_out_valid = byte_valid;
  assign rsp_if.rsp_sent       = rsp_sent;
  assign state_dbg             = state_q;

endmodule

// File: tb/tb_response_encoder.sv
// Bench for response_encoder: one instance with checksum, one without,
// directed frames plus randomized frames against a byte-list reference model.
module tb_response_encoder;
  import analyzer_pkg::*;

  logic        clock;
  logic        reset;
  logic        sel;
  logic        rsp_valid;
  logic        byte_out_ready;
  logic [7:0]  opcode;
  logic [31:0] response;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];

  response_encoder_if if0 ();
  response_encoder_if if1 ();
  rsp_state_e st0;
  rsp_state_e st1;

  response_encoder #(.CHECKSUM_EN(1'b0)) dut0 (
    .clock     (clock),
    .reset     (reset),
    .rsp_if    (if0),
    .state_dbg (st0)
  );

  response_encoder #(.CHECKSUM_EN(1'b1)) dut1 (
    .clock     (clock),
    .reset     (reset),
    .rsp_if    (if1),
    .state_dbg (st1)
  );

  // Only the selected instance sees a request; the other stays idle.
  assign if0.rsp_valid      = rsp_valid & ~sel;
  assign if1.rsp_valid      = rsp_valid & sel;
  assign if0.opcode         = opcode;
  assign if1.opcode         = opcode;
  assign if0.response       = response;
  assign if1.response       = response;
  assign if0.byte_out_ready = byte_out_ready;
  assign if1.byte_out_ready = byte_out_ready;

  logic       m_rsp_ready;
  logic [7:0] m_byte;
  logic       m_valid;
  logic       m_sent;
  rsp_state_e m_state;
  assign m_rsp_ready = sel ? if1.rsp_ready      : if0.rsp_ready;
  assign m_byte      = sel ? if1.byte_out       : if0.byte_out;
  assign m_valid     = sel ? if1.byte_out_valid : if0.byte_out_valid;
  assign m_sent      = sel ? if1.rsp_sent       : if0.rsp_sent;
  assign m_state     = sel ? st1                : st0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: opcode, payload bytes MSB first, then XOR of those five.
  function automatic void build_frame(input logic [7:0] op, input logic [31:0] rsp,
                                      input bit with_csum);
    logic [7:0] b [5];
    logic [7:0] x;
    b[0] = op;
    for (int i = 0; i < 4; i++) b[i+1] = 8'((rsp >> (24 - 8*i)) & 32'hFF);
    x = 8'h00;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(b[i]);
      x = x ^ b[i];
    end
    if (with_csum) exp_q.push_back(x);
  endfunction

  // mode 0: ready always 1; mode 1: random ready; mode 2: 3-cycle stall on BYTE1.
  // hold: keep rsp_valid high and present nop/nrsp for the following frame.
  task automatic run_frame(input bit s, input logic [7:0] op, input logic [31:0] rsp,
                           input int mode, input bit hold,
                           input logic [7:0] nop, input logic [31:0] nrsp);
    int  nbytes;
    int  stalls;
    int  stall_done;
    int  idx;
    bit  sent;
    bit  rdy;
    sel = s;
    exp_q.delete();
    build_frame(op, rsp, s);
    nbytes = exp_q.size();
    check("frame_len", nbytes, s ? FRAME_BYTES_CSUM : FRAME_BYTES_NOCSUM);
    @(negedge clock);
    check("rsp_ready_idle", m_rsp_ready, 1);
    opcode         = op;
    response       = rsp;
    rsp_valid      = 1'b1;
    byte_out_ready = 1'b1;
    stalls     = 0;
    stall_done = 0;
    sent       = 1'b0;
    for (int cyc = 1; cyc <= 64 && !sent; cyc++) begin
      @(negedge clock);
      if (cyc == 1) begin
        if (hold) begin
          opcode   = nop;
          response = nrsp;
        end else begin
          rsp_valid = 1'b0;
          opcode    = 8'($urandom);
          response  = $urandom;
        end
      end
      check("rsp_ready_busy", m_rsp_ready, 0);
      if (exp_q.size() != 0) begin
        check("byte_valid", m_valid, 1);
        check("byte_data", m_byte, exp_q[0]);
        check("no_early_sent", m_sent, 0);
        idx = nbytes - exp_q.size();
        rdy = 1'b1;
        if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
        if (mode == 2 && idx == 2 && stall_done < 3) begin
          rdy = 1'b0;
          stall_done++;
        end
        byte_out_ready = rdy;
        if (rdy) void'(exp_q.pop_front());
        else stalls++;
      end else begin
        check("sent_cycle", cyc, nbytes + stalls + 1);
        check("rsp_sent", m_sent, 1);
        check("done_valid_low", m_valid, 0);
        sent = 1'b1;
      end
    end
    check("frame_complete", sent, 1);
  endtask

  initial begin
    sel            = 1'b1;
    rsp_valid      = 1'b0;
    byte_out_ready = 1'b0;
    opcode         = 8'h00;
    response       = 32'h0;
    reset          = 1'b0;

    // Reset state on both instances.
    repeat (3) @(negedge clock);
    check("rst_valid1", if1.byte_out_valid, 0);
    check("rst_byte1", if1.byte_out, 8'h00);
    check("rst_sent1", if1.rsp_sent, 0);
    check("rst_valid0", if0.byte_out_valid, 0);
    check("rst_sent0", if0.rsp_sent, 0);
    reset = 1'b1;
    @(negedge clock);
    check("post_rst_ready1", if1.rsp_ready, 1);
    check("post_rst_ready0", if0.rsp_ready, 1);
    check("post_rst_state1", st1, IDLE);
    check("post_rst_state0", st0, IDLE);

    // Reference frame with and without checksum.
    run_frame(1'b1, 8'h5A, 32'h12345678, 0, 1'b0, 8'h00, 32'h0);
    run_frame(1'b0, 8'h5A, 32'h12345678, 0, 1'b0, 8'h00, 32'h0);

    // Back-pressure during BYTE1.
    run_frame(1'b1, 8'h5A, 32'h12345678, 2, 1'b0, 8'h00, 32'h0);

    // Inputs change mid-frame with rsp_valid held; the held request follows.
    run_frame(1'b1, 8'h5A, 32'h12345678, 0, 1'b1, 8'hA5, 32'hDEADBEEF);
    run_frame(1'b1, 8'hA5, 32'hDEADBEEF, 0, 1'b0, 8'h00, 32'h0);

    // Reset while BYTE2 is on the bus.
    sel = 1'b1;
    @(negedge clock);
    check("rr_ready", m_rsp_ready, 1);
    opcode         = 8'h5A;
    response       = 32'h12345678;
    rsp_valid      = 1'b1;
    byte_out_ready = 1'b1;
    repeat (4) begin
      @(negedge clock);
      rsp_valid = 1'b0;
    end
    check("rr_byte2", m_byte, 8'h56);
    check("rr_valid_pre", m_valid, 1);
    reset = 1'b0;
    #1;
    check("rr_valid_now", m_valid, 0);
    check("rr_byte_now", m_byte, 8'h00);
    check("rr_sent_now", m_sent, 0);
    check("rr_state_now", m_state, IDLE);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check("rr_quiet_sent", m_sent, 0);
      check("rr_quiet_valid", m_valid, 0);
    end
    run_frame(1'b1, 8'h5A, 32'h12345678, 0, 1'b0, 8'h00, 32'h0);

    // Back-to-back all-zero then all-ones frames.
    run_frame(1'b1, 8'h01, 32'h00000000, 0, 1'b1, 8'hFF, 32'hFFFFFFFF);
    run_frame(1'b1, 8'hFF, 32'hFFFFFFFF, 0, 1'b0, 8'h00, 32'h0);

    // Randomized frames with random back-pressure on both instances.
    for (int k = 0; k < 10; k++) begin
      run_frame(1'($urandom_range(0, 1)), 8'($urandom), $urandom, 1, 1'b0, 8'h00, 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/response_encoder.md
RESPONSE_ENCODER -- requirements
Module: response_encoder

Interface
REQ-001 The block SHALL have parameter CHECKSUM_EN, default 1; when 1, a sixth byte carries an XOR checksum, and when 0 exactly five bytes are sent.
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port rsp_valid, input, 1, response request from the requester.
REQ-005 The block SHALL have port rsp_ready, output, 1, encoder can accept a response.
REQ-006 The block SHALL have port opcode, input, 8, response opcode, sampled on accept.
REQ-007 The block SHALL have port response, input, 32, response payload, sampled on accept.
REQ-008 The block SHALL have port byte_out, output, 8, serialized byte to the byte transmitter.
REQ-009 The block SHALL have port byte_out_valid, output, 1, byte_out holds a valid byte.
REQ-010 The block SHALL have port byte_out_ready, input, 1, transmitter accepts byte_out this cycle.
REQ-011 The block SHALL have port rsp_sent, output, 1, one-cycle pulse after the last byte is accepted.

Function
REQ-012 States SHALL be IDLE, OPC, BYTE0, BYTE1, BYTE2, BYTE3, CSUM and DONE.
REQ-013 rsp_ready SHALL be 1 only in IDLE; accept occurs when rsp_valid && rsp_ready, and the block then latches opcode/response and moves to OPC.
REQ-014 Byte order SHALL be: OPC=opcode, BYTE0=response[31:24], BYTE1=[23:16], BYTE2=[15:8], BYTE3=[7:0], CSUM=XOR of the five preceding bytes.
REQ-015 byte_out_valid SHALL be 1 in OPC..CSUM; the state advances only on byte_out_valid && byte_out_ready.
REQ-016 While byte_out_valid=1 and byte_out_ready=0, byte_out SHALL hold stable, and the state SHALL hold.
REQ-017 BYTE3 accepted SHALL go to CSUM if CHECKSUM_EN=1, else to DONE; CSUM accepted SHALL go to DONE.
REQ-018 DONE SHALL assert rsp_sent for exactly one cycle with byte_out_valid=0, then return to IDLE.
REQ-019 With byte_out_ready held 1: accept at cycle 0, bytes on cycles 1..6 (1..5 if CHECKSUM_EN=0), rsp_sent on cycle 7 (6), rsp_ready again on cycle 8 (7).
REQ-020 All outputs SHALL be registered or decoded from the state register only, with no combinational path from rsp_valid or byte_out_ready to any output.
REQ-021 A change in opcode/response after accept SHALL NOT affect bytes in flight.
REQ-022 rsp_valid asserted outside IDLE SHALL be ignored; the request is taken on return to IDLE if still asserted.
REQ-023 Unused state encodings SHALL return to IDLE on the next clock with all outputs inactive.

Reset
REQ-024 reset=0 SHALL immediately force IDLE, byte_out=8'h00, byte_out_valid=0, rsp_sent=0, rsp_ready=1 after release, and clear the latched payload and checksum.
REQ-025 Reset mid-response SHALL abandon the frame, with no further bytes and no rsp_sent.

Structure
REQ-026 The state enum, the byte-count constants (5/6) and OPCODE_W=8 / PAYLOAD_W=32 SHALL live in the shared package analyzer_pkg, shared with the command-side decoder.
REQ-027 The block SHALL be a single module with no sub-module; checksum accumulation is an inline 8-bit XOR register updated on each accepted byte.

Verification
REQ-028 With opcode=8'h5A, response=32'h12345678, CHECKSUM_EN=1 and byte_out_ready=1, the bench SHALL see bytes 5A,12,34,56,78,52 on cycles 1-6 and rsp_sent on cycle 7.
REQ-029 With the same frame and CHECKSUM_EN=0, the bench SHALL see five bytes 5A..78 and rsp_sent on cycle 6, with no CSUM byte.
REQ-030 With byte_out_ready=0 for 3 cycles during BYTE1, the bench SHALL see byte_out=8'h34 held stable with byte_out_valid=1, and the frame resumes unchanged.
REQ-031 With rsp_valid held and the inputs changed to 8'hA5/32'hDEADBEEF mid-frame, the first frame SHALL be unaffected and the second frame SHALL start the cycle after returning to IDLE.
REQ-032 With reset asserted during BYTE2, the bench SHALL see byte_out_valid=0 immediately, no rsp_sent, and after release the next frame completes normally.
REQ-033 Two back-to-back frames 8'h01/32'h00000000 then 8'hFF/32'hFFFFFFFF SHALL produce checksums 8'h01 and 8'hFF respectively.
